// File: rtl/fb_loader_pkg.sv
// Shared definitions for the UART framebuffer loader: parser states,
// packet framing constants, default address window and small helpers.
package fb_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int PKT_LEN = 8;
    // Payload bytes between the address bytes and the checksum byte.
    localparam int DATA_BYTES = PKT_LEN - 4;

    localparam int WORD_LO_DEF = 768;
    localparam int WORD_HI_DEF = 19967;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_DATA    = 3'd3,
        ST_CHK     = 3'd4,
        ST_WRITE   = 3'd5
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fb_port_mux.sv
// Arbitration of the single framebuffer MMIO port between scanout reads
// and loader writes. Scanout wins unless a write has waited long enough.
module fb_port_mux #(
    parameter int STARVE_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        scan_req_i,
    input  logic [31:0] scan_addr_i,
    output logic        grant_o,
    output logic        scan_stall_o,
    output logic [31:0] mmio_addr_o,
    output logic        mmio_wen_o,
    output logic [31:0] mmio_wdata_o
);

    // One spare bit keeps the width legal even for a zero limit.
    localparam int WW = $clog2(STARVE_LIMIT + 2);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

    logic [WW-1:0] wait_q;
    logic          sel_q;
    logic [31:0]   waddr_q;
    logic [31:0]   wdata_q;

    assign grant_o = wr_req_i && (!scan_req_i || (wait_q >= WAIT_MAX));

    // Starvation counter: cycles spent waiting, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (!wr_req_i || grant_o) begin
            wait_q <= '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    // Registered write issue: select, address and data captured on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            sel_q <= grant_o;
            if (grant_o) begin
                waddr_q <= wr_addr_i;
                wdata_q <= wr_data_i;
            end
        end
    end

    // Scanout address passes straight through except in the write cycle.
    assign mmio_addr_o  = sel_q ? waddr_q : scan_addr_i;
    assign mmio_wen_o   = sel_q;
    assign mmio_wdata_o = wdata_q;
    assign scan_stall_o = sel_q & scan_req_i;

endmodule

// File: rtl/fb_uart_loader.sv
// UART packet parser that assembles framebuffer word writes, checks them
// and hands them to the MMIO port arbiter. Pixel clock domain.
module fb_uart_loader
    import fb_loader_pkg::*;
#(
    parameter int WORD_LO        = WORD_LO_DEF,
    parameter int WORD_HI        = WORD_HI_DEF,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int STARVE_LIMIT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        scan_req,
    input  logic [31:0] scan_addr,
    output logic        scan_stall,
    output logic [31:0] mmio_addr,
    output logic        mmio_wen,
    output logic [31:0] mmio_wdata,
    output logic        busy,
    output logic [15:0] pkt_count,
    output logic [7:0]  err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    IDX_LAST = 2'(DATA_BYTES - 1);
    localparam logic [31:0]   LO_W     = 32'(WORD_LO);
    localparam logic [31:0]   HI_W     = 32'(WORD_HI);

    state_e        state_q, state_d;
    logic [15:0]   addr_q;
    logic [31:0]   data_q;
    logic [7:0]    chk_q;
    logic [1:0]    idx_q;
    logic [TW-1:0] tmo_q;
    logic [15:0]   pkt_q;
    logic [7:0]    err_q;

    logic          parsing;
    logic          tmo_hit;
    logic          addr_ok;
    logic          chk_ok;
    logic          grant;
    logic          err_inc;
    logic          pkt_inc;
    logic [31:0]   addr_word;

    assign addr_word = {16'h0000, addr_q};
    assign parsing   = state_q inside {ST_ADDR_HI, ST_ADDR_LO, ST_DATA, ST_CHK};
    // A byte arriving on the expiry cycle keeps the packet alive.
    assign tmo_hit   = parsing && !rx_valid && (tmo_q == TMO_LAST);
    assign addr_ok   = (addr_word >= LO_W) && (addr_word <= HI_W);
    assign chk_ok    = (chk_q == rx_byte);

    // Parser next state plus the error/commit events it produces.
    always_comb begin
        state_d = state_q;
        err_inc = 1'b0;
        pkt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_byte == SYNC_BYTE)) state_d = ST_ADDR_HI;
            end
            ST_ADDR_HI: begin
                if (rx_valid) state_d = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
                if (rx_valid) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (rx_valid && (idx_q == IDX_LAST)) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (rx_valid) begin
                    // Bad checksum and bad address together still cost one error.
                    if (chk_ok && addr_ok) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_IDLE;
                        err_inc = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (grant) begin
                    state_d = ST_IDLE;
                    pkt_inc = 1'b1;
                end
                // Bytes arriving while the write waits are lost.
                if (rx_valid) err_inc = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
        end
    end

    // Parser state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Packet assembly: address, data shifted in LSB-first, running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            chk_q  <= '0;
        end else if (rx_valid) begin
            case (state_q)
                ST_ADDR_HI: begin
                    addr_q[15:8] <= rx_byte;
                    chk_q        <= rx_byte;
                end
                ST_ADDR_LO: begin
                    addr_q[7:0] <= rx_byte;
                    chk_q       <= chk_q ^ rx_byte;
                end
                ST_DATA: begin
                    data_q <= {rx_byte, data_q[31:8]};
                    chk_q  <= chk_q ^ rx_byte;
                end
                default: ;
            endcase
        end
    end

    // Payload byte index, parked at zero outside a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (state_q == ST_IDLE) begin
            idx_q <= '0;
        end else if (rx_valid && (state_q == ST_DATA)) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    // Inter-byte gap counter, only running while a packet is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (rx_valid || !parsing || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // Commit counter wraps; error counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q <= '0;
            err_q <= '0;
        end else begin
            if (pkt_inc) pkt_q <= pkt_q + 16'd1;
            if (err_inc) err_q <= sat_inc8(err_q);
        end
    end

    fb_port_mux #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_port_mux (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req_i     (state_q == ST_WRITE),
        .wr_addr_i    (addr_word),
        .wr_data_i    (data_q),
        .scan_req_i   (scan_req),
        .scan_addr_i  (scan_addr),
        .grant_o      (grant),
        .scan_stall_o (scan_stall),
        .mmio_addr_o  (mmio_addr),
        .mmio_wen_o   (mmio_wen),
        .mmio_wdata_o (mmio_wdata)
    );

    assign busy      = (state_q != ST_IDLE);
    assign pkt_count = pkt_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_fb_uart_loader.sv
// Directed bench for fb_uart_loader: packet table plus hand sequences for
// starvation, overrun, timeout, mid-packet reset and error saturation.
module tb_fb_uart_loader;

    localparam int T_OUT  = 200;
    localparam int STARVE = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        scan_req;
    logic [31:0] scan_addr;
    logic        scan_stall;
    logic [31:0] mmio_addr;
    logic        mmio_wen;
    logic [31:0] mmio_wdata;
    logic        busy;
    logic [15:0] pkt_count;
    logic [7:0]  err_count;

    int n_vec = 0;
    int n_bad = 0;
    int exp_pkt = 0;
    int exp_err = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [7:0]  flip;
        bit          exp_wr;
    } vec_t;

    vec_t vt [9];

    always #5 clk = ~clk;

    fb_uart_loader #(
        .WORD_LO        (768),
        .WORD_HI        (19967),
        .TIMEOUT_CYCLES (T_OUT),
        .STARVE_LIMIT   (STARVE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .scan_req   (scan_req),
        .scan_addr  (scan_addr),
        .scan_stall (scan_stall),
        .mmio_addr  (mmio_addr),
        .mmio_wen   (mmio_wen),
        .mmio_wdata (mmio_wdata),
        .busy       (busy),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] a, input logic [31:0] d, input logic [7:0] flip);
        logic [7:0] c;
        c = a[15:8] ^ a[7:0] ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
        send_byte(8'hA5);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(d[7:0]);
        send_byte(d[15:8]);
        send_byte(d[23:16]);
        send_byte(d[31:24]);
        send_byte(c ^ flip);
    endtask

    // Observe a window of cycles with scan_req low: count write pulses,
    // capture the write, and count cycles where the port output is wrong.
    task automatic watch(input int ncyc, output int pulses, output logic [31:0] a,
                         output logic [31:0] d, output int mux_err);
        pulses  = 0;
        a       = '0;
        d       = '0;
        mux_err = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (mmio_wen === 1'b1) begin
                pulses++;
                a = mmio_addr;
                d = mmio_wdata;
            end else if (mmio_addr !== scan_addr) begin
                mux_err++;
            end
            if (scan_stall !== 1'b0) mux_err++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, " pkt_count"}, {16'h0, pkt_count}, 32'(exp_pkt));
        check({tag, " err_count"}, {24'h0, err_count}, 32'(exp_err));
        check({tag, " busy"}, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        int          pulses;
        int          merr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        exp_w;

        vt[0] = '{16'h0300, 32'h44332211, 8'h00, 1'b1};
        vt[1] = '{16'h0300, 32'h44332211, 8'h0F, 1'b0};
        vt[2] = '{16'h0010, 32'h44332211, 8'h00, 1'b0};
        vt[3] = '{16'h4DFF, 32'hDEADBEEF, 8'h00, 1'b1};
        vt[4] = '{16'h4E00, 32'h12345678, 8'h00, 1'b0};
        vt[5] = '{16'h02FF, 32'h12345678, 8'h00, 1'b0};
        vt[6] = '{16'h0400, 32'h0100A5A5, 8'h00, 1'b1};
        vt[7] = '{16'h4E00, 32'h00000000, 8'hFF, 1'b0};
        vt[8] = '{16'h1234, 32'h00000000, 8'h00, 1'b1};

        // Reset state
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        scan_req  = 1'b0;
        scan_addr = 32'h0000_1234;
        #1;
        check("rst mmio_addr", mmio_addr, 32'h0000_1234);
        check("rst mmio_wen", {31'h0, mmio_wen}, 32'd0);
        check("rst mmio_wdata", mmio_wdata, 32'd0);
        check("rst scan_stall", {31'h0, scan_stall}, 32'd0);
        check_counts("rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table of packets with scan_req low
        for (int k = 0; k < 9; k++) begin
            scan_addr = 32'h0000_2000 + 32'(k);
            send_pkt(vt[k].addr, vt[k].data, vt[k].flip);
            watch(12, pulses, wa, wd, merr);
            if (vt[k].exp_wr) exp_pkt++;
            else exp_err++;
            check($sformatf("v%0d wen_pulses", k), 32'(pulses), vt[k].exp_wr ? 32'd1 : 32'd0);
            check($sformatf("v%0d mmio_addr", k), wa, vt[k].exp_wr ? {16'h0, vt[k].addr} : 32'd0);
            check($sformatf("v%0d mmio_wdata", k), wd, vt[k].exp_wr ? vt[k].data : 32'd0);
            check($sformatf("v%0d port_mux", k), 32'(merr), 32'd0);
            check_counts($sformatf("v%0d", k));
        end

        // Starvation: scanout never lets go, write forced on wait cycle 64
        scan_req  = 1'b1;
        scan_addr = 32'h0000_5000;
        send_pkt(16'h0500, 32'hCAFEF00D, 8'h00);
        wd = '0;
        for (int i = 0; i < 80; i++) begin
            scan_addr = 32'h0000_5000 + 32'(i);
            #1;
            exp_w = (i == STARVE + 1);
            if (mmio_wen === 1'b1) wd = mmio_wdata;
            check($sformatf("starve c%0d wen", i), {31'h0, mmio_wen}, {31'h0, exp_w});
            check($sformatf("starve c%0d stall", i), {31'h0, scan_stall}, {31'h0, exp_w});
            check($sformatf("starve c%0d addr", i), mmio_addr, exp_w ? 32'h0000_0500 : scan_addr);
            @(posedge clk);
            #1;
        end
        scan_req = 1'b0;
        exp_pkt++;
        check("starve wdata", wd, 32'hCAFEF00D);
        check_counts("starve");

        // Overrun: byte arrives while the write is held off
        scan_req = 1'b1;
        send_pkt(16'h0600, 32'h01020304, 8'h00);
        send_byte(8'h5A);
        scan_req = 1'b0;
        watch(10, pulses, wa, wd, merr);
        exp_pkt++;
        exp_err++;
        check("overrun wen_pulses", 32'(pulses), 32'd1);
        check("overrun mmio_addr", wa, 32'h0000_0600);
        check("overrun mmio_wdata", wd, 32'h01020304);
        check_counts("overrun");

        // Timeout: a byte on the expiry cycle survives, silence does not
        send_byte(8'hA5);
        repeat (T_OUT - 1) @(posedge clk);
        #1;
        send_byte(8'h03);
        check("tmo byte_wins busy", {31'h0, busy}, 32'd1);
        repeat (T_OUT - 1) @(posedge clk);
        #1;
        check("tmo before busy", {31'h0, busy}, 32'd1);
        check("tmo before err", {24'h0, err_count}, 32'(exp_err));
        @(posedge clk);
        #1;
        exp_err++;
        check_counts("tmo expired");
        send_pkt(16'h0300, 32'h44332211, 8'h00);
        watch(10, pulses, wa, wd, merr);
        exp_pkt++;
        check("tmo after wen_pulses", 32'(pulses), 32'd1);
        check("tmo after mmio_wdata", wd, 32'h44332211);
        check_counts("tmo after");

        // Reset between d2 and d3
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst_n     = 1'b0;
        scan_addr = 32'h0000_0ABC;
        #1;
        exp_pkt = 0;
        exp_err = 0;
        check("midrst mmio_addr", mmio_addr, 32'h0000_0ABC);
        check("midrst mmio_wen", {31'h0, mmio_wen}, 32'd0);
        check_counts("midrst during");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'h44);
        send_byte(8'h47);
        watch(10, pulses, wa, wd, merr);
        check("midrst wen_pulses", 32'(pulses), 32'd0);
        check_counts("midrst after");

        // Error counter saturation
        for (int p = 0; p < 300; p++) begin
            send_pkt(16'h0300, 32'h44332211, 8'h0F);
            if (p == 253) check("sat err_254", {24'h0, err_count}, 32'd254);
        end
        exp_err = 255;
        check_counts("sat");
        send_pkt(16'h0300, 32'h44332211, 8'h00);
        watch(10, pulses, wa, wd, merr);
        exp_pkt++;
        check("sat after wen_pulses", 32'(pulses), 32'd1);
        check_counts("sat after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_uart_loader.md
# fb_uart_loader

Packet-driven framebuffer writer that turns the UART byte stream into 32-bit MMIO word writes, and arbitrates the single framebuffer MMIO port between the HDMI scanout reader and these writes. It sits between `uart_receive` and the CPU's MMIO framebuffer port. It runs in the pixel clock domain; the UART strobe is already synchronised into this domain upstream. Scanout has priority, and a starvation guard bounds how long a pending write can wait.

## Interface
Parameters:
- `WORD_LO`, default 768: lowest legal framebuffer word address (byte base 0xC00 / 4).
- `WORD_HI`, default 19967: highest legal word address (320×240 bytes / 4 words above `WORD_LO`).
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle gap between bytes inside a packet.
- `STARVE_LIMIT`, default 64: wait cycles before a write may pre-empt scanout.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  pixel clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_byte` is valid.
- `rx_byte`  in  8  received UART byte.
- `scan_req`  in  1  scanout needs the port this cycle.
- `scan_addr`  in  32  scanout word address.
- `scan_stall`  out  1  scanout's read this cycle was displaced by a write.
- `mmio_addr`  out  32  word address to the MMIO port.
- `mmio_wen`  out  1  write enable, one cycle per accepted packet.
- `mmio_wdata`  out  32  write data.
- `busy`  out  1  parser is not in IDLE.
- `pkt_count`  out  16  writes committed; wraps modulo 2^16.
- `err_count`  out  8  rejected packets and overruns; saturates at 255.

## Operation
- Packet format, 8 bytes: `0xA5`, `addr_hi`, `addr_lo`, `d0`, `d1`, `d2`, `d3`, `chk`.
  - `chk` = XOR of `addr_hi`, `addr_lo` and `d0`–`d3`.
  - Write data = {`d3`,`d2`,`d1`,`d0`}; `d0` is bits [7:0].
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, CHK, WRITE.
  - IDLE: non-`0xA5` bytes are ignored silently. `0xA5` → ADDR_HI.
  - ADDR_HI → ADDR_LO → DATA, one byte each.
  - DATA: a 2-bit index counts 4 bytes, then → CHK.
  - CHK: checksum match and address in [`WORD_LO`, `WORD_HI`] → WRITE. Otherwise `err_count`+1 → IDLE.
  - WRITE: wait for grant, issue the write, `pkt_count`+1 → IDLE.
- Timeout: a cycle counter clears on each `rx_valid`. In any state other than IDLE or WRITE, reaching `TIMEOUT_CYCLES` → IDLE, `err_count`+1.
- Overrun: `rx_valid` while in WRITE drops the byte and increments `err_count`.
- Arbitration:
  - Write is granted when in WRITE and either `scan_req`=0 or the wait counter ≥ `STARVE_LIMIT`.
  - The wait counter counts cycles spent in WRITE and clears on leaving WRITE.
  - On grant: `mmio_addr`=latched write address, `mmio_wen`=1, `mmio_wdata`=latched data.
  - If `scan_req`=1 during that grant cycle, `scan_stall`=1.
  - All other cycles: `mmio_addr`=`scan_addr`, `mmio_wen`=0.

## Timing
- Reset values: state IDLE, `mmio_wen`=0, `mmio_wdata`=0, `scan_stall`=0, `busy`=0, `pkt_count`=0, `err_count`=0, all counters 0. `mmio_addr` follows `scan_addr` during reset.
- Reset asserted mid-packet or in WRITE: the partial packet is discarded and no write is issued.
- `mmio_addr` is a combinational mux of `scan_addr` and a registered grant select, with zero added latency for scanout.
- `mmio_wen` and `mmio_wdata` are registered.
- Grant latency:
  - `scan_req`=0: the write issues the cycle after entering WRITE.
  - Worst case: `STARVE_LIMIT`+1 cycles after entering WRITE.
- Exactly one `mmio_wen` pulse per accepted packet.
- `rx_valid` in the same cycle the timeout would expire: the byte wins and the timeout counter clears.
- A CHK failure and an out-of-range address in the same packet count as one error.
- `0xA5` arriving mid-packet is treated as data (no resync).

## Structure
- Package `fb_loader_pkg`: state enum, `SYNC_BYTE`=8'hA5, `PKT_LEN`=8, shared `WORD_LO`/`WORD_HI` defaults.
- Sub-module `fb_port_mux`: grant logic, starvation counter and output mux.
- Parser FSM, assembly registers and counters live in the top.

## Test plan
- Send `A5 03 00 11 22 33 44 47` with `scan_req`=0 → one `mmio_wen` pulse, `mmio_addr`=0x300, `mmio_wdata`=0x44332211, `pkt_count`=1.
- Same packet with the last byte `48` → no write, `err_count`=1, `busy`=0 afterwards.
- Valid packet to address 0x0010 (checksum correct) → no write, `err_count`=1.
- Hold `scan_req`=1 continuously and send a valid packet → write issues on wait cycle 64 with `scan_stall`=1 for exactly that cycle; `mmio_addr`=`scan_addr` on every other cycle.
- Send `A5 03`, then silence for 1_000_000 cycles → IDLE, `err_count`=1. Then send a full valid packet → committed.
- Assert `rst_n`=0 between `d2` and `d3` → no `mmio_wen`, all counters 0; `err_count` saturation check with 300 bad packets → 255.
